// File: rtl/aes_byte_serializer.sv
// Byte serializer feeding key_expansion_control: streams a 128-bit key and
// state MSB-first, one byte per cycle, with one pending block behind the active one.
module aes_byte_serializer #(
  parameter int NBYTES = 16,
  parameter int BW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBYTES*BW-1:0] in_key,
  input  logic [NBYTES*BW-1:0] in_state,
  output logic [BW-1:0]        out_key_byte,
  output logic [BW-1:0]        out_mix_byte,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy
);
  localparam int W  = NBYTES * BW;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  key_q, key_d, st_q, st_d;
  logic [W-1:0]  pkey_q, pkey_d, pst_q, pst_d;
  logic          pend_full_q, pend_full_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          xfer, at_last;

  assign in_ready = !pend_full_q && !rst;
  assign xfer     = in_valid && in_ready;
  assign at_last  = (idx_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = STREAM;
      STREAM:  if (at_last && !pend_full_q && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid    = (state_q == STREAM);
    out_first    = (state_q == STREAM) && (idx_q == '0);
    out_last     = (state_q == STREAM) && at_last;
    busy         = (state_q == STREAM) || pend_full_q;
    out_key_byte = key_q[W-1 -: BW];
    out_mix_byte = st_q[W-1 -: BW];
  end

  // Zero-fill on shift means the active buffer is all zero once a block drains,
  // so the byte outputs read 0x00 in IDLE without extra gating.
  always_comb begin
    key_d       = key_q;
    st_d        = st_q;
    pkey_d      = pkey_q;
    pst_d       = pst_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          key_d = in_key;
          st_d  = in_state;
          idx_d = '0;
        end
      end
      STREAM: begin
        key_d = {key_q[W-BW-1:0], {BW{1'b0}}};
        st_d  = {st_q[W-BW-1:0], {BW{1'b0}}};
        idx_d = idx_q + IW'(1);
        if (at_last) begin
          idx_d = '0;
          if (pend_full_q) begin
            key_d       = pkey_q;
            st_d        = pst_q;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            key_d = in_key;
            st_d  = in_state;
          end
        end else if (xfer) begin
          pkey_d      = in_key;
          pst_d       = in_state;
          pend_full_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      st_q        <= '0;
      pkey_q      <= '0;
      pst_q       <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      key_q       <= key_d;
      st_q        <= st_d;
      pkey_q      <= pkey_d;
      pst_q       <= pst_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
    end
  end
endmodule
